// File: rtl/vga_seg_display_if.sv
// Signal bundle between the time-keeping logic and the seven-segment VGA renderer.
// Defining SEG_DISP_DIGIT_BLINK_EN adds the per-digit blink_mask input.
interface vga_seg_display_if #(
  parameter int NUM_DIGITS = 9
);
  logic [7*NUM_DIGITS-1:0] seg;
  logic                    colon_en;
`ifdef SEG_DISP_DIGIT_BLINK_EN
  logic [NUM_DIGITS-1:0]   blink_mask;
`endif
  logic                    frame_start;
  logic                    VGA_HS_O;
  logic                    VGA_VS_O;
  logic [3:0]              VGA_R;
  logic [3:0]              VGA_G;
  logic [3:0]              VGA_B;

`ifdef SEG_DISP_DIGIT_BLINK_EN
  modport master (output seg, colon_en, blink_mask,
                  input  frame_start, VGA_HS_O, VGA_VS_O, VGA_R, VGA_G, VGA_B);
  modport slave  (input  seg, colon_en, blink_mask,
                  output frame_start, VGA_HS_O, VGA_VS_O, VGA_R, VGA_G, VGA_B);
`else
  modport master (output seg, colon_en,
                  input  frame_start, VGA_HS_O, VGA_VS_O, VGA_R, VGA_G, VGA_B);
  modport slave  (input  seg, colon_en,
                  output frame_start, VGA_HS_O, VGA_VS_O, VGA_R, VGA_G, VGA_B);
`endif
endinterface

// File: rtl/vga_seg_display.sv
// 640x480@60 VGA renderer for a row of seven-segment digits with blinking colons.
// Optional SEG_DISP_DIGIT_BLINK_EN: per-digit blanking on the blink phase via blink_mask.
module vga_seg_display #(
  parameter int                    NUM_DIGITS   = 9,
  parameter int                    SEG_LEN      = 40,
  parameter int                    SEG_THK      = 5,
  parameter int                    DIGIT_GAP    = 25,
  parameter int                    X0           = 25,
  parameter int                    Y0           = 195,
  parameter logic [NUM_DIGITS-1:0] COLON_MASK   = 9'b000_010_100,
  parameter logic [11:0]           FG_RGB       = 12'hF00,
  parameter int                    BLINK_FRAMES = 30,
  parameter int                    H_VIS        = 640,
  parameter int                    H_FP         = 16,
  parameter int                    H_SYNC       = 96,
  parameter int                    H_BP         = 48,
  parameter int                    V_VIS        = 480,
  parameter int                    V_FP         = 10,
  parameter int                    V_SYNC       = 2,
  parameter int                    V_BP         = 33
) (
  input  logic               CLK,
  input  logic               RST_BTN,
  vga_seg_display_if.slave   bus
);
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int FCW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int T     = SEG_THK;
  localparam int L     = SEG_LEN;
  localparam int W     = L + 2*T;
  localparam int HH    = 2*L + 3*T;
  localparam int PITCH = W + DIGIT_GAP;
  localparam int CU    = W + (DIGIT_GAP - 2*T)/2;
  localparam int CV0   = L/2;
  localparam int CV1   = T + L + L/2;

  logic [1:0]              stb_cnt_r;
  logic [HW-1:0]           h_r;
  logic [VW-1:0]           v_r;
  logic [FCW-1:0]          fcnt_r;
  logic                    blink_ph_r;
  logic                    loaded_r;
  logic [7*NUM_DIGITS-1:0] shadow_r;
  logic                    fs_r;
  logic                    hs_r;
  logic                    vs_r;
  logic [11:0]             rgb_r;

  logic                    pix_stb_s;
  logic                    latch_s;
  logic                    visible_s;
  logic                    hsync_s;
  logic                    vsync_s;
  logic                    colon_on_s;
  logic                    hit_s;
  logic                    lit_s;
  logic [NUM_DIGITS-1:0]   dblank_s;
  int                      vp_s;

  function automatic logic in_rng(input int x, input int lo, input int hi);
    return (x >= lo) && (x < hi);
  endfunction

  // Segment bits are active-low, ordered {a,b,c,d,e,f,g}.
  function automatic logic seg_hit(input int u, input int vp, input logic [6:0] s);
    return (!s[6] && in_rng(u, T,   T+L) && in_rng(vp, 0,       T))
        || (!s[5] && in_rng(u, T+L, W)   && in_rng(vp, T,       T+L))
        || (!s[4] && in_rng(u, T+L, W)   && in_rng(vp, 2*T+L,   2*T+2*L))
        || (!s[3] && in_rng(u, T,   T+L) && in_rng(vp, 2*T+2*L, HH))
        || (!s[2] && in_rng(u, 0,   T)   && in_rng(vp, 2*T+L,   2*T+2*L))
        || (!s[1] && in_rng(u, 0,   T)   && in_rng(vp, T,       T+L))
        || (!s[0] && in_rng(u, T,   T+L) && in_rng(vp, T+L,     2*T+L));
  endfunction

  function automatic logic colon_hit(input int u, input int vp);
    return in_rng(u, CU, CU + 2*T)
        && (in_rng(vp, CV0, CV0 + 2*T) || in_rng(vp, CV1, CV1 + 2*T));
  endfunction

  assign pix_stb_s  = (stb_cnt_r == 2'd3);
  assign latch_s    = pix_stb_s && (h_r == {HW{1'b0}}) && (v_r == VW'(V_VIS));
  assign visible_s  = (h_r < HW'(H_VIS)) && (v_r < VW'(V_VIS));
  assign hsync_s    = (h_r >= HW'(H_VIS + H_FP)) && (h_r < HW'(H_VIS + H_FP + H_SYNC));
  assign vsync_s    = (v_r >= VW'(V_VIS + V_FP)) && (v_r < VW'(V_VIS + V_FP + V_SYNC));
  assign colon_on_s = bus.colon_en & ~blink_ph_r;
  assign vp_s       = int'(v_r) - Y0;

`ifdef SEG_DISP_DIGIT_BLINK_EN
  logic [NUM_DIGITS-1:0] mask_r;
  assign dblank_s = mask_r & {NUM_DIGITS{blink_ph_r}};

  // Digit blink mask shadow, loaded alongside the segment shadow
  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      mask_r <= {NUM_DIGITS{1'b0}};
    end else if (latch_s) begin
      mask_r <= bus.blink_mask;
    end else begin
      mask_r <= mask_r;
    end
  end
`else
  assign dblank_s = {NUM_DIGITS{1'b0}};
`endif

  // Hit test of the current pixel against every digit and colon rectangle
  always_comb begin
    hit_s = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      hit_s = hit_s
            | seg_hit(int'(h_r) - (X0 + k*PITCH), vp_s,
                      shadow_r[7*(NUM_DIGITS-1-k) +: 7] | {7{dblank_s[k]}})
            | (COLON_MASK[k] & colon_on_s & colon_hit(int'(h_r) - (X0 + k*PITCH), vp_s));
    end
  end

  // Nothing is drawn until a real segment frame has been latched
  assign lit_s = visible_s & loaded_r & hit_s;

  // Pixel strobe divider: one strobe every fourth CLK
  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      stb_cnt_r <= 2'd0;
    end else begin
      stb_cnt_r <= stb_cnt_r + 2'd1;
    end
  end

  // Horizontal and vertical raster counters
  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      h_r <= {HW{1'b0}};
      v_r <= {VW{1'b0}};
    end else if (pix_stb_s) begin
      if (h_r == HW'(H_TOT - 1)) begin
        h_r <= {HW{1'b0}};
        v_r <= (v_r == VW'(V_TOT - 1)) ? {VW{1'b0}} : v_r + VW'(1);
      end else begin
        h_r <= h_r + HW'(1);
      end
    end else begin
      h_r <= h_r;
    end
  end

  // Frame latch: segment shadow, frame counter and blink phase
  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      shadow_r   <= {7*NUM_DIGITS{1'b1}};
      loaded_r   <= 1'b0;
      fcnt_r     <= {FCW{1'b0}};
      blink_ph_r <= 1'b0;
      fs_r       <= 1'b0;
    end else begin
      fs_r <= latch_s;
      if (latch_s) begin
        shadow_r <= bus.seg;
        loaded_r <= 1'b1;
        if (fcnt_r == FCW'(BLINK_FRAMES - 1)) begin
          fcnt_r     <= {FCW{1'b0}};
          blink_ph_r <= ~blink_ph_r;
        end else begin
          fcnt_r <= fcnt_r + FCW'(1);
        end
      end else begin
        shadow_r <= shadow_r;
      end
    end
  end

  // Sync and colour registered together so they stay pixel-aligned
  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      hs_r  <= 1'b1;
      vs_r  <= 1'b1;
      rgb_r <= 12'h000;
    end else if (pix_stb_s) begin
      hs_r  <= ~hsync_s;
      vs_r  <= ~vsync_s;
      rgb_r <= lit_s ? FG_RGB : 12'h000;
    end else begin
      rgb_r <= rgb_r;
    end
  end

  assign bus.frame_start = fs_r;
  assign bus.VGA_HS_O    = hs_r;
  assign bus.VGA_VS_O    = vs_r;
  assign bus.VGA_R       = rgb_r[11:8];
  assign bus.VGA_G       = rgb_r[7:4];
  assign bus.VGA_B       = rgb_r[3:0];
endmodule

// File: tb/tb_vga_seg_display.sv
// Bench for vga_seg_display on a shrunken raster and digit geometry, checked pixel by pixel
// against a rectangle-list model; define SEG_DISP_DIGIT_BLINK_EN to cover digit blinking.
module tb_vga_seg_display;
  localparam int          ND    = 3;
  localparam int          L     = 4;
  localparam int          T     = 1;
  localparam int          GAP   = 3;
  localparam int          X0    = 2;
  localparam int          Y0    = 2;
  localparam logic [2:0]  CMASK = 3'b011;
  localparam logic [11:0] FG    = 12'hF00;
  localparam int          BF    = 3;
  localparam int          HVIS = 24, HFP = 2, HSYNC = 4, HBP = 2;
  localparam int          VVIS = 16, VFP = 2, VSYNC = 2, VBP = 2;
  localparam int          HT    = HVIS + HFP + HSYNC + HBP;
  localparam int          VT    = VVIS + VFP + VSYNC + VBP;
  localparam int          FRAME = HT * VT;
  localparam int          SW    = 7 * ND;
  localparam int          W     = L + 2*T;
  localparam int          HH    = 2*L + 3*T;
  localparam int          CU    = W + (GAP - 2*T)/2;

  // Segment rectangles a..g in digit-local coordinates
  localparam int ULO[7] = '{T,   T+L, T+L,     T,       0,       0,   T};
  localparam int UHI[7] = '{T+L, W,   W,       T+L,     T,       T,   T+L};
  localparam int VLO[7] = '{0,   T,   2*T+L,   2*T+2*L, 2*T+L,   T,   T+L};
  localparam int VHI[7] = '{T,   T+L, 2*T+2*L, HH,      2*T+2*L, T+L, 2*T+L};

  logic CLK = 1'b0;
  logic RST_BTN;
  int   vectors = 0;
  int   miscompares = 0;

  int            n_lat;
  logic [SW-1:0] m_seg;
  logic [ND-1:0] m_mask;

  vga_seg_display_if #(.NUM_DIGITS(ND)) bus ();

  vga_seg_display #(
    .NUM_DIGITS(ND), .SEG_LEN(L), .SEG_THK(T), .DIGIT_GAP(GAP), .X0(X0), .Y0(Y0),
    .COLON_MASK(CMASK), .FG_RGB(FG), .BLINK_FRAMES(BF),
    .H_VIS(HVIS), .H_FP(HFP), .H_SYNC(HSYNC), .H_BP(HBP),
    .V_VIS(VVIS), .V_FP(VFP), .V_SYNC(VSYNC), .V_BP(VBP)
  ) dut (
    .CLK(CLK),
    .RST_BTN(RST_BTN),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Reference state: what the display should have latched so far
  always @(negedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      n_lat  <= 0;
      m_seg  <= '1;
      m_mask <= '0;
    end else if (bus.frame_start) begin
      n_lat <= n_lat + 1;
      m_seg <= bus.seg;
`ifdef SEG_DISP_DIGIT_BLINK_EN
      m_mask <= bus.blink_mask;
`endif
    end
  end

  function automatic logic [11:0] exp_rgb(input int h, input int v);
    int   u, vp;
    logic ph, lit, blank;
    ph  = ((n_lat / BF) % 2) == 1;
    lit = 1'b0;
    if (h < HVIS && v < VVIS && n_lat > 0) begin
      vp = v - Y0;
      for (int k = 0; k < ND; k++) begin
        u = h - (X0 + k*(W + GAP));
        blank = m_mask[k] && ph;
        for (int s = 0; s < 7; s++)
          if (!blank && !m_seg[7*(ND-1-k) + 6 - s] &&
              u >= ULO[s] && u < UHI[s] && vp >= VLO[s] && vp < VHI[s])
            lit = 1'b1;
        if (CMASK[k] && bus.colon_en && !ph && u >= CU && u < CU + 2*T &&
            ((vp >= L/2 && vp < L/2 + 2*T) || (vp >= T+L+L/2 && vp < T+L+L/2 + 2*T)))
          lit = 1'b1;
      end
    end
    return lit ? FG : 12'h000;
  endfunction

  task automatic wait_first_latch(output int cyc, output int lit_cnt, output bit seen);
    cyc = 0; lit_cnt = 0; seen = 1'b0;
    for (int i = 0; i < 2*FRAME*4; i++) begin
      @(posedge CLK); #1;
      cyc++;
      if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} != 12'h000) lit_cnt++;
      if (bus.frame_start) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_frames(input int nf, input int chg_row, input logic [SW-1:0] chg_seg);
    int          h, v, p, hs_low, vs_low;
    logic [14:0] got, exp;
    bit          seen;
    seen = 1'b0;
    for (int i = 0; i < FRAME*4 + 16; i++) begin
      @(posedge CLK); #1;
      if (bus.frame_start) begin
        seen = 1'b1;
        break;
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL frame_start_timeout: none within %0d clocks, required one", FRAME*4 + 16);
      return;
    end
    for (int f = 0; f < nf; f++) begin
      hs_low = 0; vs_low = 0;
      for (int k = 0; k < FRAME; k++) begin
        if (k > 0 || f > 0) repeat (4) begin @(posedge CLK); #1; end
        p = (VVIS*HT + k) % FRAME;
        h = p % HT;
        v = p / HT;
        exp = {(k == 0),
               !(h >= HVIS+HFP && h < HVIS+HFP+HSYNC),
               !(v >= VVIS+VFP && v < VVIS+VFP+VSYNC),
               exp_rgb(h, v)};
        got = {bus.frame_start, bus.VGA_HS_O, bus.VGA_VS_O, bus.VGA_R, bus.VGA_G, bus.VGA_B};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL pixel h=%0d v=%0d frame=%0d {fs,hs,vs,rgb}: got %h required %h",
                   h, v, f, got, exp);
        end
        if (!bus.VGA_HS_O) hs_low++;
        if (!bus.VGA_VS_O) vs_low++;
        if (chg_row >= 0 && f == 0 && h == 0 && v == chg_row) bus.seg = chg_seg;
      end
      vectors++;
      if (hs_low !== VT*HSYNC) begin
        miscompares++;
        $display("FAIL hsync_low_count: got %0d required %0d", hs_low, VT*HSYNC);
      end
      vectors++;
      if (vs_low !== VSYNC*HT) begin
        miscompares++;
        $display("FAIL vsync_low_count: got %0d required %0d", vs_low, VSYNC*HT);
      end
    end
  endtask

  task automatic test_reset();
    int cyc, lit_cnt;
    bit seen;
    RST_BTN      = 1'b0;
    bus.seg      = SW'($urandom);
    bus.colon_en = 1'b1;
`ifdef SEG_DISP_DIGIT_BLINK_EN
    bus.blink_mask = '0;
`endif
    repeat (10) @(posedge CLK);
    #1;
    vectors++;
    if ({bus.frame_start, bus.VGA_HS_O, bus.VGA_VS_O, bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 15'h3000) begin
      miscompares++;
      $display("FAIL reset_outputs: got fs=%b hs=%b vs=%b rgb=%h required 0 1 1 000",
               bus.frame_start, bus.VGA_HS_O, bus.VGA_VS_O, {bus.VGA_R, bus.VGA_G, bus.VGA_B});
    end
    @(negedge CLK);
    RST_BTN = 1'b1;
    wait_first_latch(cyc, lit_cnt, seen);
    vectors++;
    if (!seen || cyc < 4*VVIS*HT - 4 || cyc > 4*VVIS*HT + 4) begin
      miscompares++;
      $display("FAIL first_latch_delay: got %0d clocks (seen=%0d) required %0d +/-4",
               cyc, seen, 4*VVIS*HT);
    end
    vectors++;
    if (lit_cnt !== 0) begin
      miscompares++;
      $display("FAIL blank_before_latch: got %0d lit samples required 0", lit_cnt);
    end
  endtask

  task automatic test_render();
    logic [SW-1:0] s;
    s = '1;
    s[SW-1 -: 7] = 7'b0000000;
    bus.seg      = s;
    bus.colon_en = 1'b0;
    check_frames(1, -1, '0);
  endtask

  task automatic test_tear_free();
    bus.seg      = SW'($urandom);
    bus.colon_en = 1'($urandom);
    check_frames(2, VVIS/2, SW'($urandom));
  endtask

  task automatic test_random();
    for (int i = 0; i < 2; i++) begin
      bus.seg      = SW'($urandom);
      bus.colon_en = 1'($urandom);
`ifdef SEG_DISP_DIGIT_BLINK_EN
      bus.blink_mask = ND'($urandom);
`endif
      check_frames(1, -1, '0);
    end
  endtask

  task automatic test_colon_blink();
    bus.seg      = '0;
    bus.colon_en = 1'b1;
`ifdef SEG_DISP_DIGIT_BLINK_EN
    bus.blink_mask = ND'($urandom_range(1, (1 << ND) - 1));
`endif
    check_frames(2*BF + 1, -1, '0);
  endtask

  task automatic test_mid_reset();
    int cyc, lit_cnt;
    bit seen;
    repeat ($urandom_range(200, 1500)) @(posedge CLK);
    #2;
    RST_BTN = 1'b0;
    #1;
    vectors++;
    if ({bus.frame_start, bus.VGA_HS_O, bus.VGA_VS_O, bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 15'h3000) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got fs=%b hs=%b vs=%b rgb=%h required 0 1 1 000",
               bus.frame_start, bus.VGA_HS_O, bus.VGA_VS_O, {bus.VGA_R, bus.VGA_G, bus.VGA_B});
    end
    bus.seg      = '0;
    bus.colon_en = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_BTN = 1'b1;
    wait_first_latch(cyc, lit_cnt, seen);
    vectors++;
    if (!seen || lit_cnt !== 0) begin
      miscompares++;
      $display("FAIL mid_reset_blank: got %0d lit samples (seen=%0d) required 0 then a latch",
               lit_cnt, seen);
    end
    check_frames(1, -1, '0);
  endtask

  initial begin
    test_reset();
    test_render();
    test_tear_free();
    test_random();
    test_colon_blink();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
